rand_pos_gen: RTL and testbench
===============================

RAND_POS_GEN -- requirements
Module: rand_pos_gen

Interface
REQ-001 The block SHALL have parameter X_W, default 10: x coordinate width, 2..16.
REQ-002 The block SHALL have parameter Y_W, default 10: y coordinate width, 2..16.
REQ-003 The block SHALL have parameter X_MIN, default 0: lowest legal x.
REQ-004 The block SHALL have parameter X_MAX, default 959: highest legal x, with X_MIN <= X_MAX <= 2^X_W-1.
REQ-005 The block SHALL have parameter Y_MIN, default 96: lowest legal y.
REQ-006 The block SHALL have parameter Y_MAX, default 607: highest legal y, with Y_MIN <= Y_MAX <= 2^Y_W-1.
REQ-007 The block SHALL have parameter MAX_TRIES, default 8: candidate cycles before fallback, 1..255.
REQ-008 The block SHALL have parameter SEED_X, default 16'hACE1: reset/seed value of the x LFSR, nonzero.
REQ-009 The block SHALL have parameter SEED_Y, default 16'h1F35: reset/seed value of the y LFSR, nonzero.
REQ-010 clk  in  1  sole clock; all state changes on its rising edge.
REQ-011 rst  in  1  asynchronous, active-high reset.
REQ-012 req  in  1  request for a new position; sampled in IDLE only.
REQ-013 ready  in  1  consumer accepts the presented position.
REQ-014 valid  out  1  x_pos/y_pos hold a new position.
REQ-015 x_pos  out  X_W  generated x.
REQ-016 y_pos  out  Y_W  generated y.
REQ-017 fallback  out  1  at least one coordinate of the current position is the range midpoint, not a random hit.
REQ-018 busy  out  1  high in GEN and VALID states.

Function
REQ-019 Two 16-bit Galois LFSRs (x, y), polynomial x^16+x^14+x^13+x^11+1 (mask 16'hB400), SHALL each advance one step every clock in every state.
REQ-020 An LFSR that would reach 16'h0000 SHALL load its SEED value instead.
REQ-021 States: IDLE, GEN, VALID; IDLE -> GEN on req=1; GEN -> VALID when both coordinates are settled; VALID -> IDLE on ready=1.
REQ-022 In GEN, each cycle x candidate = lfsr_x[X_W-1:0], y candidate = lfsr_y[Y_W-1:0], compared unsigned against [MIN, MAX] inclusive.
REQ-023 Each coordinate SHALL latch independently on its first in-range candidate and stay unchanged for the rest of that GEN.
REQ-024 A try counter SHALL count GEN cycles; after MAX_TRIES cycles, every unsettled coordinate SHALL take (MIN+MAX)>>1 and fallback SHALL be set.
REQ-025 GEN SHALL last between 1 and MAX_TRIES cycles; valid SHALL rise the cycle after GEN ends.
REQ-026 While valid=1, x_pos, y_pos and fallback SHALL be stable; valid falls the cycle after ready=1 is sampled.
REQ-027 req in GEN or VALID SHALL be ignored, with no queuing; req and ready high together in VALID SHALL return the block to IDLE only.
REQ-028 In IDLE, x_pos/y_pos SHALL keep the last delivered position.

Reset
REQ-029 While rst=1, regardless of clk: state=IDLE, valid=0, busy=0, fallback=0, lfsr_x=SEED_X, lfsr_y=SEED_Y, try counter=0, x_pos=(X_MIN+X_MAX)>>1, y_pos=(Y_MIN+Y_MAX)>>1.
REQ-030 Reset asserted mid-GEN or mid-VALID SHALL discard the pending position; no valid pulse follows.

Configuration
REQ-031 Macro RAND_POS_SEED_LOAD_EN defined: ports seed_load (in, 1) and seed (in, 16) SHALL exist; seed_load=1 in any state loads lfsr_x=seed, lfsr_y=seed^16'h5A5A, zero results replaced per REQ-020, aborts GEN/VALID to IDLE with valid=0.
REQ-032 Macro RAND_POS_SEED_LOAD_EN undefined: seed_load and seed ports SHALL be absent, and the LFSRs SHALL reseed only via reset.

Verification
REQ-033 Reset with defaults -> x_pos=479, y_pos=351, valid=0, busy=0, fallback=0.
REQ-034 Defaults, 1000 req pulses, ready=1 -> each valid within 1..9 cycles of req; 0<=x_pos<=959; 96<=y_pos<=607; values match the bench LFSR model.
REQ-035 X_MIN=X_MAX=700, MAX_TRIES=1 -> x_pos=700 every time; fallback matches the model.
REQ-036 ready=0 for 20 cycles after valid, with req pulsed meanwhile -> valid, x_pos, y_pos held 20 cycles; one delivery only.
REQ-037 rst pulsed on the 2nd GEN cycle -> REQ-029 values immediately; no valid afterwards without a new req.
REQ-038 RAND_POS_SEED_LOAD_EN, seed_load with seed=16'h0000 during VALID -> valid=0 next cycle, lfsr_x=SEED_X, lfsr_y=16'h5A5A.

Source files
------------

// File: rtl/rand_pos_if.sv
// rand_pos_if -- request/deliver bundle for rand_pos_gen.
//
// Signals:
//   req      requester -> generator  ask for a new position
//   ready    requester -> generator  consumer accepts the presented position
//   valid    generator -> requester  x_pos/y_pos hold a new position
//   x_pos    generator -> requester  generated x (X_W bits)
//   y_pos    generator -> requester  generated y (Y_W bits)
//   fallback generator -> requester  at least one coordinate is the range midpoint
//   busy     generator -> requester  generator is generating or presenting
//
// Modports: master = requester/consumer side, slave = generator side.
interface rand_pos_if #(
    parameter int X_W = 10,
    parameter int Y_W = 10
);
    logic           req;
    logic           ready;
    logic           valid;
    logic [X_W-1:0] x_pos;
    logic [Y_W-1:0] y_pos;
    logic           fallback;
    logic           busy;

    modport master (
        output req, ready,
        input  valid, x_pos, y_pos, fallback, busy
    );

    modport slave (
        input  req, ready,
        output valid, x_pos, y_pos, fallback, busy
    );
endinterface

// File: rtl/rand_pos_gen.sv
// rand_pos_gen -- pseudo-random (x, y) position generator with range limits.
//
// Two free-running 16-bit Galois LFSRs (mask 16'hB400) supply candidates.
// On a request the block spends up to MAX_TRIES cycles looking for an
// in-range value for each coordinate independently; any coordinate still
// unsettled afterwards takes its range midpoint and fallback is flagged.
//
// Ports:
//   clk        sole clock, rising edge
//   rst        asynchronous active-high reset
//   bus        rand_pos_if.slave (req, ready in; valid, x_pos, y_pos,
//              fallback, busy out)
//   seed_load  (only with RAND_POS_SEED_LOAD_EN) reseed both LFSRs and
//              abort to IDLE
//   seed       (only with RAND_POS_SEED_LOAD_EN) 16-bit reseed value;
//              x gets seed, y gets seed ^ 16'h5A5A
//
// Configuration macro: RAND_POS_SEED_LOAD_EN enables the runtime reseed
// ports; without it the LFSRs reseed only through rst.
module rand_pos_gen #(
    parameter int          X_W       = 10,
    parameter int          Y_W       = 10,
    parameter int          X_MIN     = 0,
    parameter int          X_MAX     = 959,
    parameter int          Y_MIN     = 96,
    parameter int          Y_MAX     = 607,
    parameter int          MAX_TRIES = 8,
    parameter logic [15:0] SEED_X    = 16'hACE1,
    parameter logic [15:0] SEED_Y    = 16'h1F35
) (
    input  logic        clk,
    input  logic        rst,
    rand_pos_if.slave   bus
`ifdef RAND_POS_SEED_LOAD_EN
    ,
    input  logic        seed_load,
    input  logic [15:0] seed
`endif
);

    typedef enum logic [1:0] {ST_IDLE, ST_GEN, ST_VALID} state_t;

    // Bounds are widened by one bit so the range test never compares an
    // unsigned value against zero or against its own all-ones maximum.
    localparam logic [X_W:0]   X_MIN_E  = X_MIN[X_W:0];
    localparam logic [X_W:0]   X_MAX_E  = X_MAX[X_W:0];
    localparam logic [Y_W:0]   Y_MIN_E  = Y_MIN[Y_W:0];
    localparam logic [Y_W:0]   Y_MAX_E  = Y_MAX[Y_W:0];
    localparam logic [X_W:0]   X_ONE    = 1;
    localparam logic [Y_W:0]   Y_ONE    = 1;
    localparam int             X_MID    = (X_MIN + X_MAX) / 2;
    localparam int             Y_MID    = (Y_MIN + Y_MAX) / 2;
    localparam logic [X_W-1:0] X_MID_V  = X_MID[X_W-1:0];
    localparam logic [Y_W-1:0] Y_MID_V  = Y_MID[Y_W-1:0];
    localparam int             LAST_INT = MAX_TRIES - 1;
    localparam logic [7:0]     LAST_TRY = LAST_INT[7:0];

    state_t         state_reg, state_next;
    logic [15:0]    lfsr_x_reg, lfsr_y_reg;
    logic [15:0]    lfsr_x_next, lfsr_y_next;
    logic [7:0]     try_cnt_reg;
    logic           x_hit_reg, y_hit_reg;
    logic [X_W-1:0] x_val_reg, x_pos_reg;
    logic [Y_W-1:0] y_val_reg, y_pos_reg;
    logic           fallback_reg;

    logic [X_W-1:0] x_cand;
    logic [Y_W-1:0] y_cand;
    logic           x_in, y_in, x_now, y_now;
    logic           last_try, gen_done, abort;

    // One Galois step; the all-zero lock-up state is replaced by the seed.
    function automatic logic [15:0] lfsr_step(input logic [15:0] s,
                                              input logic [15:0] reseed);
        logic [15:0] n;
        n = {1'b0, s[15:1]} ^ (s[0] ? 16'hB400 : 16'h0000);
        return (n == 16'h0000) ? reseed : n;
    endfunction

`ifdef RAND_POS_SEED_LOAD_EN
    logic [15:0] seed_y;
    assign seed_y      = seed ^ 16'h5A5A;
    assign abort       = seed_load;
    assign lfsr_x_next = !seed_load ? lfsr_step(lfsr_x_reg, SEED_X)
                       : (seed == 16'h0000) ? SEED_X : seed;
    assign lfsr_y_next = !seed_load ? lfsr_step(lfsr_y_reg, SEED_Y)
                       : (seed_y == 16'h0000) ? SEED_Y : seed_y;
`else
    assign abort       = 1'b0;
    assign lfsr_x_next = lfsr_step(lfsr_x_reg, SEED_X);
    assign lfsr_y_next = lfsr_step(lfsr_y_reg, SEED_Y);
`endif

    assign x_cand   = lfsr_x_reg[X_W-1:0];
    assign y_cand   = lfsr_y_reg[Y_W-1:0];
    // (c + 1) > MIN is the same test as c >= MIN.
    assign x_in     = (({1'b0, x_cand} + X_ONE) > X_MIN_E) && ({1'b0, x_cand} <= X_MAX_E);
    assign y_in     = (({1'b0, y_cand} + Y_ONE) > Y_MIN_E) && ({1'b0, y_cand} <= Y_MAX_E);
    // Settled either earlier in this GEN or by this cycle's candidate.
    assign x_now    = x_hit_reg || x_in;
    assign y_now    = y_hit_reg || y_in;
    assign last_try = (try_cnt_reg == LAST_TRY);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_reg <= ST_IDLE;
        else     state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        gen_done   = 1'b0;
        case (state_reg)
            ST_IDLE:  if (bus.req) state_next = ST_GEN;
            ST_GEN: begin
                if ((x_now && y_now) || last_try) begin
                    state_next = ST_VALID;
                    gen_done   = 1'b1;
                end
            end
            ST_VALID: if (bus.ready) state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
        if (abort) begin
            state_next = ST_IDLE;
            gen_done   = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lfsr_x_reg   <= SEED_X;
            lfsr_y_reg   <= SEED_Y;
            try_cnt_reg  <= '0;
            x_hit_reg    <= 1'b0;
            y_hit_reg    <= 1'b0;
            x_val_reg    <= '0;
            y_val_reg    <= '0;
            x_pos_reg    <= X_MID_V;
            y_pos_reg    <= Y_MID_V;
            fallback_reg <= 1'b0;
        end else begin
            lfsr_x_reg <= lfsr_x_next;
            lfsr_y_reg <= lfsr_y_next;
            // Hits are staged separately so an aborted GEN never disturbs
            // the last delivered position.
            if (state_reg == ST_GEN && !abort) begin
                try_cnt_reg <= try_cnt_reg + 8'd1;
                if (!x_hit_reg && x_in) begin
                    x_hit_reg <= 1'b1;
                    x_val_reg <= x_cand;
                end
                if (!y_hit_reg && y_in) begin
                    y_hit_reg <= 1'b1;
                    y_val_reg <= y_cand;
                end
            end else begin
                try_cnt_reg <= '0;
                x_hit_reg   <= 1'b0;
                y_hit_reg   <= 1'b0;
            end
            if (gen_done) begin
                x_pos_reg    <= x_hit_reg ? x_val_reg : (x_in ? x_cand : X_MID_V);
                y_pos_reg    <= y_hit_reg ? y_val_reg : (y_in ? y_cand : Y_MID_V);
                fallback_reg <= !(x_now && y_now);
            end
        end
    end

    assign bus.valid    = (state_reg == ST_VALID);
    assign bus.busy     = (state_reg != ST_IDLE);
    assign bus.x_pos    = x_pos_reg;
    assign bus.y_pos    = y_pos_reg;
    assign bus.fallback = fallback_reg;

endmodule

// File: tb/tb_rand_pos_gen.sv
// tb_rand_pos_gen -- scoreboard bench for rand_pos_gen.
// u_dut uses default parameters; u_dut2 pins x to 700 with a single try.
// Expected positions come from a bench LFSR model and are queued at request
// time; per-DUT monitors pop and compare whenever valid is presented.
module tb_rand_pos_gen;

    localparam logic [15:0] SEED_X = 16'hACE1;
    localparam logic [15:0] SEED_Y = 16'h1F35;

    typedef struct {
        int x;
        int y;
        bit fb;
        int due;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic req = 1'b0;
    logic ready = 1'b1;
`ifdef RAND_POS_SEED_LOAD_EN
    logic        seed_load = 1'b0;
    logic [15:0] seed = 16'h0000;
`endif

    rand_pos_if #(.X_W(10), .Y_W(10)) bus0();
    rand_pos_if #(.X_W(10), .Y_W(10)) bus1();

    assign bus0.req   = req;
    assign bus0.ready = ready;
    assign bus1.req   = req;
    assign bus1.ready = ready;

    rand_pos_gen u_dut (
        .clk(clk),
        .rst(rst),
        .bus(bus0.slave)
`ifdef RAND_POS_SEED_LOAD_EN
        ,
        .seed_load(seed_load),
        .seed(seed)
`endif
    );

    rand_pos_gen #(.X_MIN(700), .X_MAX(700), .MAX_TRIES(1)) u_dut2 (
        .clk(clk),
        .rst(rst),
        .bus(bus1.slave)
`ifdef RAND_POS_SEED_LOAD_EN
        ,
        .seed_load(seed_load),
        .seed(seed)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int vectors = 0;
    int errors  = 0;
    int deliv0  = 0;
    int deliv1  = 0;
    exp_t q0[$];
    exp_t q1[$];

    function automatic logic [15:0] step(input logic [15:0] s, input logic [15:0] reseed);
        logic [15:0] n;
        n = s >> 1;
        if (s[0]) n = n ^ 16'hB400;
        if (n == 16'h0000) n = reseed;
        return n;
    endfunction

    // Bench copy of the two LFSRs: advance every clock, reseed on reset.
    logic [15:0] mx, my;
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mx <= SEED_X;
            my <= SEED_Y;
        end
`ifdef RAND_POS_SEED_LOAD_EN
        else if (seed_load) begin
            mx <= (seed == 16'h0000) ? SEED_X : seed;
            my <= ((seed ^ 16'h5A5A) == 16'h0000) ? SEED_Y : (seed ^ 16'h5A5A);
        end
`endif
        else begin
            mx <= step(mx, SEED_X);
            my <= step(my, SEED_Y);
        end
    end

    // sx/sy are the LFSR values seen at the clock edge that samples req;
    // GEN cycle k tests the k-th successor of that state.
    function automatic exp_t predict(input logic [15:0] sx, input logic [15:0] sy,
                                     input int xmin, input int xmax,
                                     input int ymin, input int ymax,
                                     input int tries, input int issue_cyc);
        exp_t r;
        bit xh, yh, done;
        int xv, yv, xc, yc, len;
        xh = 0; yh = 0; done = 0; xv = 0; yv = 0; len = tries;
        for (int k = 1; k <= tries; k++) begin
            if (!done) begin
                sx = step(sx, SEED_X);
                sy = step(sy, SEED_Y);
                xc = int'(sx[9:0]);
                yc = int'(sy[9:0]);
                if (!xh && xc >= xmin && xc <= xmax) begin xh = 1; xv = xc; end
                if (!yh && yc >= ymin && yc <= ymax) begin yh = 1; yv = yc; end
                if (xh && yh) begin done = 1; len = k; end
            end
        end
        r.x   = xh ? xv : (xmin + xmax) / 2;
        r.y   = yh ? yv : (ymin + ymax) / 2;
        r.fb  = !(xh && yh);
        r.due = issue_cyc + len + 1;
        return r;
    endfunction

    task automatic chk(input string name, input int act, input int exp_v);
        vectors++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp_v, cyc);
        end
    endtask

    task automatic fail_now(input string name);
        vectors++;
        errors++;
        $display("FAIL %s: timed out (cycle %0d)", name, cyc);
    endtask

    // Monitors: pop on the rising edge of valid, then check every cycle
    // that valid stays high so holding is verified too.
    bit   pv0 = 0, pv1 = 0, have0 = 0, have1 = 0;
    exp_t cur0, cur1;

    always @(negedge clk) begin
        if (rst) begin
            pv0 = 0; have0 = 0;
        end else begin
            if (bus0.valid && !pv0) begin
                deliv0++;
                if (q0.size() == 0) begin
                    vectors++; errors++; have0 = 0;
                    $display("FAIL dut0_unexpected_valid: got valid=1, expected no delivery (cycle %0d)", cyc);
                end else begin
                    cur0 = q0.pop_front();
                    have0 = 1;
                    chk("dut0_latency", cyc, cur0.due);
                    chk("dut0_x_in_range", int'(bus0.x_pos <= 10'd959), 1);
                    chk("dut0_y_in_range", int'(bus0.y_pos >= 10'd96 && bus0.y_pos <= 10'd607), 1);
                    $display("dut0 delivery %0d: x=%0d y=%0d fb=%0d", deliv0, bus0.x_pos, bus0.y_pos, bus0.fallback);
                end
            end
            if (bus0.valid && have0) begin
                chk("dut0_x", int'(bus0.x_pos), cur0.x);
                chk("dut0_y", int'(bus0.y_pos), cur0.y);
                chk("dut0_fallback", int'(bus0.fallback), int'(cur0.fb));
                chk("dut0_busy", int'(bus0.busy), 1);
            end
            pv0 = bus0.valid;
        end
    end

    always @(negedge clk) begin
        if (rst) begin
            pv1 = 0; have1 = 0;
        end else begin
            if (bus1.valid && !pv1) begin
                deliv1++;
                if (q1.size() == 0) begin
                    vectors++; errors++; have1 = 0;
                    $display("FAIL dut2_unexpected_valid: got valid=1, expected no delivery (cycle %0d)", cyc);
                end else begin
                    cur1 = q1.pop_front();
                    have1 = 1;
                    chk("dut2_latency", cyc, cur1.due);
                    chk("dut2_x_pinned", int'(bus1.x_pos), 700);
                end
            end
            if (bus1.valid && have1) begin
                chk("dut2_x", int'(bus1.x_pos), cur1.x);
                chk("dut2_y", int'(bus1.y_pos), cur1.y);
                chk("dut2_fallback", int'(bus1.fallback), int'(cur1.fb));
            end
            pv1 = bus1.valid;
        end
    end

    // Called at a negedge with both DUTs idle; leaves req low one cycle later.
    task automatic issue(input bit push);
        exp_t e0, e1;
        e0 = predict(mx, my, 0, 959, 96, 607, 8, cyc);
        e1 = predict(mx, my, 700, 700, 96, 607, 1, cyc);
        if (push) begin
            q0.push_back(e0);
            q1.push_back(e1);
        end
        req = 1'b1;
        @(negedge clk);
        req = 1'b0;
    endtask

    task automatic wait_idle();
        bit ok = 0;
        for (int i = 0; i < 40 && !ok; i++) begin
            if (q0.size() == 0 && q1.size() == 0 && !bus0.busy && !bus1.busy
                && !bus0.valid && !bus1.valid) ok = 1;
            else @(negedge clk);
        end
        if (!ok) begin
            fail_now("wait_idle");
            q0.delete();
            q1.delete();
        end
    endtask

    task automatic wait_both_valid();
        bit ok = 0;
        for (int i = 0; i < 20 && !ok; i++) begin
            if (bus0.valid && bus1.valid) ok = 1;
            else @(negedge clk);
        end
        if (!ok) fail_now("wait_valid");
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_x0"}, int'(bus0.x_pos), 479);
        chk({tag, "_y0"}, int'(bus0.y_pos), 351);
        chk({tag, "_valid0"}, int'(bus0.valid), 0);
        chk({tag, "_busy0"}, int'(bus0.busy), 0);
        chk({tag, "_fb0"}, int'(bus0.fallback), 0);
        chk({tag, "_x2"}, int'(bus1.x_pos), 700);
        chk({tag, "_y2"}, int'(bus1.y_pos), 351);
        chk({tag, "_valid2"}, int'(bus1.valid), 0);
        chk({tag, "_fb2"}, int'(bus1.fallback), 0);
    endtask

    initial begin
        int d0, d1;

        // Reset is asynchronous: values must appear before any clock edge.
        #1 rst = 1'b1;
        #2 check_reset_values("reset");
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Back-to-back requests with ready held high and varying idle gaps.
        ready = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            repeat (i % 3) @(negedge clk);
            issue(1);
            wait_idle();
        end

        // Consumer stalls for 20 cycles; req pulses meanwhile are ignored.
        ready = 1'b0;
        issue(1);
        wait_both_valid();
        for (int i = 0; i < 20; i++) begin
            req = (i == 5 || (i >= 12 && i <= 14));
            @(negedge clk);
            chk("hold_valid0", int'(bus0.valid), 1);
            chk("hold_valid2", int'(bus1.valid), 1);
        end
        d0 = deliv0;
        d1 = deliv1;
        req   = 1'b1;           // req together with ready: back to IDLE only
        ready = 1'b1;
        @(negedge clk);
        req = 1'b0;
        chk("release_valid0", int'(bus0.valid), 0);
        chk("release_valid2", int'(bus1.valid), 0);
        chk("release_busy0", int'(bus0.busy), 0);
        repeat (15) @(negedge clk);
        chk("single_delivery0", deliv0 - d0, 0);
        chk("single_delivery2", deliv1 - d1, 0);

        // Reset during the second GEN cycle discards the request.
        d0 = deliv0;
        d1 = deliv1;
        req = 1'b1;
        @(posedge clk);
        #1 req = 1'b0;
        @(posedge clk);
        #2 rst = 1'b1;
        #1 check_reset_values("midgen_rst");
        @(negedge clk);
        rst = 1'b0;
        repeat (15) @(negedge clk);
        chk("no_valid_after_rst0", deliv0 - d0, 0);
        chk("no_valid_after_rst2", deliv1 - d1, 0);

`ifdef RAND_POS_SEED_LOAD_EN
        // Reseed with zero during VALID: x falls back to SEED_X.
        ready = 1'b0;
        issue(1);
        wait_both_valid();
        seed_load = 1'b1;
        seed      = 16'h0000;
        @(negedge clk);
        seed_load = 1'b0;
        chk("seed_load_valid0", int'(bus0.valid), 0);
        chk("seed_load_valid2", int'(bus1.valid), 0);
        chk("seed_load_lfsr_x", int'(u_dut.lfsr_x_reg), int'(SEED_X));
        chk("seed_load_lfsr_y", int'(u_dut.lfsr_y_reg), 32'h5A5A);
        ready = 1'b1;
        @(negedge clk);
`endif

        // More transactions to confirm the LFSR sequence after reseeding.
        for (int i = 0; i < 40; i++) begin
            repeat (i % 4) @(negedge clk);
            issue(1);
            wait_idle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

    initial begin
        #600000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

endmodule
